// File: rtl/if_else_feed_pkg.sv
// Shared types for the if/else operand feeder: data width, operand pair payload and FSM states.
package if_else_feed_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned STAT_W = 16;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } pair_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/if_else_pair_fifo.sv
// Operand-pair FIFO: storage, wrapping pointers, occupancy and registered full/empty flags.
module if_else_pair_fifo
  import if_else_feed_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  pair_t                  i_pair,
  input  logic                   i_pop,
  output pair_t                  o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_fill_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned FW = AW + 1;

  pair_t          r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [FW-1:0]  r_fill;
  logic           r_full;
  logic           r_empty;
  logic [FW-1:0]  w_fill_nxt;
  logic           w_push;
  logic           w_pop;

  // A push while full or a pop while empty is ignored.
  assign w_push = i_push && !r_full;
  assign w_pop  = i_pop && !r_empty;

  always_comb begin
    w_fill_nxt = r_fill;
    if (w_push && !w_pop) begin
      w_fill_nxt = r_fill + FW'(1);
    end else if (!w_push && w_pop) begin
      w_fill_nxt = r_fill - FW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_fill  <= w_fill_nxt;
      r_full  <= (w_fill_nxt == FW'(DEPTH));
      r_empty <= (w_fill_nxt == '0);
    end
  end

  // Storage needs no reset; occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_pair;
  end

  assign o_head       = r_mem[r_rd_ptr];
  assign o_full       = r_full;
  assign o_empty      = r_empty;
  assign o_fill_level = r_fill;

endmodule

// File: rtl/if_else_operand_feeder.sv
// Streams (a, b) pairs into the if/else stage, holds them for PIPE_LAT cycles and returns temp_combine.
// Optional delivered-result counter elem_count is enabled with IF_ELSE_FEEDER_STATS_EN.
module if_else_operand_feeder
  import if_else_feed_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned PIPE_LAT = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_a,
  input  logic [DATA_W-1:0]      in_b,
  output logic [DATA_W-1:0]      array_a_wire_0,
  output logic [DATA_W-1:0]      array_b_wire_0,
  input  logic [DATA_W-1:0]      temp_combine,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [$clog2(DEPTH):0] fill_level
`ifdef IF_ELSE_FEEDER_STATS_EN
  ,
  output logic [STAT_W-1:0]      elem_count
`endif
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  pair_t               r_op;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_valid;
  pair_t               w_head;
  pair_t               w_in_pair;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic                w_capture;
  logic                w_consume;

  assign w_in_pair = '{a: in_a, b: in_b};
  assign w_push    = in_valid && !w_full;

  if_else_pair_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (reset),
    .i_push       (w_push),
    .i_pair       (w_in_pair),
    .i_pop        (w_pop),
    .o_head       (w_head),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_fill_level (fill_level)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Pop on idle or on a result handshake; capture when the latency counter reaches 1.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_capture   = 1'b0;
    w_consume   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        if (r_cnt == CNT_W'(1)) begin
          w_capture   = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (r_out_valid && out_ready) begin
          w_consume = 1'b1;
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = DRIVE;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op        <= '0;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_pop) begin
        r_op  <= w_head;
        r_cnt <= CNT_W'(PIPE_LAT);
      end else if (r_state == DRIVE && !w_capture) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_capture) begin
        r_out_data  <= temp_combine;
        r_out_valid <= 1'b1;
      end else if (w_consume) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef IF_ELSE_FEEDER_STATS_EN
  logic [STAT_W-1:0] r_elem_count;

  // Saturating count of delivered results.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_elem_count <= '0;
    end else if (w_consume && (r_elem_count != '1)) begin
      r_elem_count <= r_elem_count + STAT_W'(1);
    end
  end

  assign elem_count = r_elem_count;
`endif

  assign in_ready       = !w_full;
  assign out_valid      = r_out_valid;
  assign out_data       = r_out_data;
  assign array_a_wire_0 = r_op.a;
  assign array_b_wire_0 = r_op.b;

endmodule
